// File: rtl/tmr_pkg.sv
// tmr_pkg: voter mode encoding, replica indices and strike-counter width helper
// shared by tmr_degrade_voter and tmr_strike_ctr.
package tmr_pkg;
    typedef enum logic [1:0] {
        MODE_TMR    = 2'd0,
        MODE_DUPLEX = 2'd1,
        MODE_FAIL   = 2'd2
    } mode_t;
    localparam int REP_A = 0;
    localparam int REP_B = 1;
    localparam int REP_C = 2;
    function automatic int strike_w(input int smax);
        return $clog2(smax + 1);
    endfunction
endpackage

// File: rtl/tmr_strike_ctr.sv
// tmr_strike_ctr: saturating consecutive-strike counter; o_hit flags the edge on which
// the count reaches MAX so the mode FSM can switch on that same edge.
module tmr_strike_ctr import tmr_pkg::*; #(
    parameter int MAX = 4,
    parameter int W   = strike_w(MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    input  logic i_freeze,
    output logic o_hit
);
    localparam logic [W-1:0] LIM = W'(MAX);
    logic [W-1:0] r_cnt;
    assign o_hit = i_inc & ~i_freeze & ~i_clr & (r_cnt >= LIM - 1'b1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (!i_freeze)
            r_cnt <= !i_inc ? '0 : (r_cnt == LIM ? LIM : r_cnt + 1'b1);
    end
endmodule

// File: rtl/tmr_degrade_voter.sv
// tmr_degrade_voter: registered bitwise TMR voter degrading TMR -> DUPLEX -> FAIL on persistent faults.
// Define TMR_FAULT_INJ_EN to let i_inj_a/b/c invert a replica before voting.
module tmr_degrade_voter import tmr_pkg::*; #(
    parameter int               WIDTH      = 8,
    parameter int               STRIKE_MAX = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic [WIDTH-1:0] i_in_c,
    input  logic             i_inj_a,
    input  logic             i_inj_b,
    input  logic             i_inj_c,
    input  logic             i_clear_faults,
    output logic [WIDTH-1:0] o_vote_out,
    output logic             o_tmr_error,
    output logic [1:0]       o_mode,
    output logic [2:0]       o_excluded,
    output logic             o_fatal
);
    logic [WIDTH-1:0] w_ra, w_rb, w_rc, w_maj, w_p, w_q, w_vote_nxt, r_vote;
    logic [2:0]       w_dis, w_hit, w_inc, w_frz, w_excl_nxt, r_excl;
    logic             w_err_nxt, r_err;
    mode_t            r_mode, w_mode_nxt;
`ifdef TMR_FAULT_INJ_EN
    assign w_ra = i_in_a ^ {WIDTH{i_inj_a}};
    assign w_rb = i_in_b ^ {WIDTH{i_inj_b}};
    assign w_rc = i_in_c ^ {WIDTH{i_inj_c}};
`else
    logic w_unused_inj;
    assign w_unused_inj = i_inj_a ^ i_inj_b ^ i_inj_c;
    assign w_ra = i_in_a;
    assign w_rb = i_in_b;
    assign w_rc = i_in_c;
`endif
    assign w_maj = (w_ra & w_rb) | (w_ra & w_rc) | (w_rb & w_rc);
    assign w_dis = {w_rc != w_maj, w_rb != w_maj, w_ra != w_maj};
    assign w_inc = (r_mode == MODE_TMR) ? w_dis : 3'b000;
    assign w_frz = r_excl | {3{r_mode == MODE_FAIL}};
    for (genvar i = 0; i < 3; i++) begin : g_ctr
        tmr_strike_ctr #(.MAX(STRIKE_MAX)) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .i_inc    (w_inc[i]),
            .i_clr    (i_clear_faults),
            .i_freeze (w_frz[i]),
            .o_hit    (w_hit[i])
        );
    end
    // The two surviving replicas in DUPLEX
    assign w_p = r_excl[REP_A] ? w_rb : w_ra;
    assign w_q = r_excl[REP_C] ? w_rb : w_rc;
    always_comb begin
        w_mode_nxt = r_mode;
        w_vote_nxt = r_vote;
        w_err_nxt  = 1'b1;
        w_excl_nxt = r_excl;
        if (i_clear_faults) begin
            w_mode_nxt = MODE_TMR;
            w_vote_nxt = w_maj;
            w_err_nxt  = 1'b0;
            w_excl_nxt = 3'b000;
        end else if (r_mode == MODE_TMR) begin
            w_vote_nxt = w_maj;
            w_err_nxt  = |w_dis;
            if (w_hit != 3'b000) begin
                w_mode_nxt = $onehot(w_hit) ? MODE_DUPLEX : MODE_FAIL;
                w_excl_nxt = $onehot(w_hit) ? w_hit : 3'b000;
            end
        end else if (r_mode == MODE_DUPLEX) begin
            w_vote_nxt = (w_p == w_q) ? w_p : r_vote;
            w_err_nxt  = w_p != w_q;
            w_mode_nxt = (w_p == w_q) ? MODE_DUPLEX : MODE_FAIL;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_TMR;
            r_vote <= RESET_VAL;
            r_err  <= 1'b0;
            r_excl <= 3'b000;
        end else begin
            r_mode <= w_mode_nxt;
            r_vote <= w_vote_nxt;
            r_err  <= w_err_nxt;
            r_excl <= w_excl_nxt;
        end
    end
    assign o_vote_out  = r_vote;
    assign o_tmr_error = r_err;
    assign o_mode      = r_mode;
    assign o_excluded  = r_excl;
    assign o_fatal     = r_mode == MODE_FAIL;
endmodule

// File: tb/tb_tmr_degrade_voter.sv
// tb_tmr_degrade_voter: table-driven directed check of the degrading TMR voter (WIDTH=8, STRIKE_MAX=4).
module tb_tmr_degrade_voter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a, b, c, vote;
    logic       ia, ib, ic, clr, err, fatal;
    logic [1:0] mode;
    logic [2:0] excl;
    int         errors = 0;
    int         checks = 0;

`ifdef TMR_FAULT_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    typedef struct {
        logic [7:0] a, b, c;
        logic [2:0] inj;
        logic       clr;
        logic [7:0] vote;
        logic       err;
        logic [1:0] mode;
        logic [2:0] excl;
    } vec_t;
    vec_t tv[$];

    tmr_degrade_voter #(.WIDTH(8), .STRIKE_MAX(4), .RESET_VAL(8'h00)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_in_a         (a),
        .i_in_b         (b),
        .i_in_c         (c),
        .i_inj_a        (ia),
        .i_inj_b        (ib),
        .i_inj_c        (ic),
        .i_clear_faults (clr),
        .o_vote_out     (vote),
        .o_tmr_error    (err),
        .o_mode         (mode),
        .o_excluded     (excl),
        .o_fatal        (fatal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] v, input logic e, input logic [1:0] m,
                           input logic [2:0] x);
        chk({tag, ".vote"}, vote, v);
        chk({tag, ".err"}, {7'd0, err}, {7'd0, e});
        chk({tag, ".mode"}, {6'd0, mode}, {6'd0, m});
        chk({tag, ".excl"}, {5'd0, excl}, {5'd0, x});
        chk({tag, ".fatal"}, {7'd0, fatal}, {7'd0, m == 2'd2});
    endtask

    task automatic add(input logic [7:0] va, vb, vc, input logic [2:0] inj, input logic cl,
                       input logic [7:0] v, input logic e, input logic [1:0] m, input logic [2:0] x,
                       input int n);
        for (int k = 0; k < n; k++) tv.push_back('{va, vb, vc, inj, cl, v, e, m, x});
    endtask

    task automatic drive(input logic [7:0] va, vb, vc, input logic [2:0] inj, input logic cl);
        a = va; b = vb; c = vc; {ic, ib, ia} = inj; clr = cl;
    endtask

    initial begin
        drive(8'h5A, 8'h5A, 8'h5A, 3'b000, 1'b0);
        // reset, strike reset on agreement, degrade to DUPLEX, DUPLEX failure, clear
        add(8'h5A, 8'h5A, 8'h5A, 3'b000, 0, 8'h5A, 0, 0, 3'b000, 1);
        add(8'h5A, 8'hA5, 8'h5A, 3'b000, 0, 8'h5A, 1, 0, 3'b000, 3);
        add(8'h5A, 8'h5A, 8'h5A, 3'b000, 0, 8'h5A, 0, 0, 3'b000, 1);
        add(8'h5A, 8'hA5, 8'h5A, 3'b000, 0, 8'h5A, 1, 0, 3'b000, 3);
        add(8'h5A, 8'hA5, 8'h5A, 3'b000, 0, 8'h5A, 1, 1, 3'b010, 1);
        add(8'h3C, 8'hFF, 8'h3C, 3'b000, 0, 8'h3C, 0, 1, 3'b010, 1);
        add(8'h11, 8'hFF, 8'h22, 3'b000, 0, 8'h3C, 1, 2, 3'b010, 2);
        add(8'h77, 8'h77, 8'h77, 3'b000, 1, 8'h77, 0, 0, 3'b000, 1);
        add(8'h77, 8'h77, 8'h77, 3'b000, 0, 8'h77, 0, 0, 3'b000, 1);
        // clear overrides the DUPLEX transition due on the same edge
        add(8'h77, 8'h00, 8'h77, 3'b000, 0, 8'h77, 1, 0, 3'b000, 3);
        add(8'h77, 8'h00, 8'h77, 3'b000, 1, 8'h77, 0, 0, 3'b000, 1);
        add(8'h77, 8'h00, 8'h77, 3'b000, 0, 8'h77, 1, 0, 3'b000, 1);
        add(8'h77, 8'h77, 8'h77, 3'b000, 0, 8'h77, 0, 0, 3'b000, 1);
        // fault injection on replica A
        add(8'hF0, 8'hF0, 8'hF0, 3'b001, 0, 8'hF0, INJ, 0, 3'b000, 3);
        add(8'hF0, 8'hF0, 8'hF0, 3'b001, 0, 8'hF0, INJ, INJ ? 2'd1 : 2'd0, INJ ? 3'b001 : 3'b000, 1);
        add(8'hF0, 8'hF0, 8'hF0, 3'b000, 1, 8'hF0, 0, 0, 3'b000, 1);
        add(8'h77, 8'h77, 8'h77, 3'b000, 0, 8'h77, 0, 0, 3'b000, 1);
        // all three disagree: maj=00, simultaneous hits -> FAIL, vote holds
        add(8'h01, 8'h02, 8'h04, 3'b000, 0, 8'h00, 1, 0, 3'b000, 3);
        add(8'h01, 8'h02, 8'h04, 3'b000, 0, 8'h00, 1, 2, 3'b000, 1);
        add(8'h99, 8'h99, 8'h99, 3'b000, 0, 8'h00, 1, 2, 3'b000, 1);

        repeat (2) @(posedge clk);
        #1 chk_all("reset", 8'h00, 0, 0, 3'b000);
        @(negedge clk) rst = 1'b0;
        foreach (tv[i]) begin
            @(negedge clk) drive(tv[i].a, tv[i].b, tv[i].c, tv[i].inj, tv[i].clr);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), tv[i].vote, tv[i].err, tv[i].mode, tv[i].excl);
        end

        // async reset mid-sequence wipes pending strikes
        @(negedge clk) drive(8'h5A, 8'hA5, 8'h5A, 3'b000, 1'b1);
        @(negedge clk) clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) #2 rst = 1'b1;
        #1 chk_all("async_rst", 8'h00, 0, 0, 3'b000);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk_all($sformatf("post_rst%0d", k), 8'h5A, 1, 0, 3'b000);
        end
        @(posedge clk);
        #1 chk_all("post_rst_dup", 8'h5A, 1, 1, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
